// File: rtl/timer_mm_pkg.sv
// Shared definitions for the timer_mm_driver: timer register map, control bits and FSM states.
// Snapshot states exist only when TIMER_MM_DRIVER_SNAPSHOT_EN is defined.
package timer_mm_pkg;

    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_CONTROL = 3'd1;
    localparam logic [2:0] REG_PERIODL = 3'd2;
    localparam logic [2:0] REG_PERIODH = 3'd3;
    localparam logic [2:0] REG_SNAPL   = 3'd4;
    localparam logic [2:0] REG_SNAPH   = 3'd5;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    typedef enum logic [3:0] {
        IDLE,
        WR_PL,
        WR_PH,
        WR_CTRL,
        RUN,
        CLR_ST,
        WR_STOP
`ifdef TIMER_MM_DRIVER_SNAPSHOT_EN
        ,
        SNAP_WR,
        SNAP_RD_L,
        SNAP_RD_H,
        SNAP_CAP
`endif
    } state_e;

    function automatic logic [15:0] ctrl_word(input logic stop, input logic start,
                                              input logic cont, input logic ito);
        logic [15:0] w;
        w = '0;
        w[CTRL_STOP]  = stop;
        w[CTRL_START] = start;
        w[CTRL_CONT]  = cont;
        w[CTRL_ITO]   = ito;
        return w;
    endfunction

endpackage

// File: rtl/timer_mm_driver_if.sv
// Avalon-MM link between the driver (master) and the interval timer slave.
interface timer_mm_driver_if;
    logic [2:0]  tm_address;
    logic        tm_chipselect;
    logic        tm_write_n;
    logic [15:0] tm_writedata;
    logic [15:0] tm_readdata;
    logic        tm_irq;

    modport master (
        output tm_address, tm_chipselect, tm_write_n, tm_writedata,
        input  tm_readdata, tm_irq
    );

    modport slave (
        input  tm_address, tm_chipselect, tm_write_n, tm_writedata,
        output tm_readdata, tm_irq
    );
endinterface

// File: rtl/timer_mm_driver.sv
// Programs an Avalon interval timer, services its timeout irq and counts ticks.
// Optional counter snapshot readout is built when TIMER_MM_DRIVER_SNAPSHOT_EN is defined.
module timer_mm_driver
    import timer_mm_pkg::*;
#(
    parameter int TICK_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_start,
    input  logic [31:0]           cfg_period,
    input  logic                  cfg_continuous,
    input  logic                  cfg_stop,
`ifdef TIMER_MM_DRIVER_SNAPSHOT_EN
    input  logic                  snap_req,
    output logic [31:0]           snap_value,
    output logic                  snap_valid,
`endif
    timer_mm_driver_if.master     tm,
    output logic                  busy,
    output logic                  running,
    output logic                  tick,
    output logic [TICK_CNT_W-1:0] tick_count
);

    state_e                state_q, state_d;
    logic [31:0]           period_q, period_d;
    logic                  cont_q, cont_d;
    logic [TICK_CNT_W-1:0] tick_count_q, tick_count_d;
    logic                  irq_now;

`ifdef TIMER_MM_DRIVER_SNAPSHOT_EN
    logic        irq_pend_q, irq_pend_d;
    logic [15:0] snap_lo_q, snap_lo_d;
    logic [31:0] snap_value_q, snap_value_d;

    // An irq seen while the bus is busy with a snapshot is held until RUN.
    assign irq_now = tm.tm_irq | irq_pend_q;
`else
    logic unused_readdata;
    assign unused_readdata = ^tm.tm_readdata;
    assign irq_now = tm.tm_irq;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            period_q     <= '0;
            cont_q       <= 1'b0;
            tick_count_q <= '0;
`ifdef TIMER_MM_DRIVER_SNAPSHOT_EN
            irq_pend_q   <= 1'b0;
            snap_lo_q    <= '0;
            snap_value_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            cont_q       <= cont_d;
            tick_count_q <= tick_count_d;
`ifdef TIMER_MM_DRIVER_SNAPSHOT_EN
            irq_pend_q   <= irq_pend_d;
            snap_lo_q    <= snap_lo_d;
            snap_value_q <= snap_value_d;
`endif
        end
    end

    always_comb begin
        state_d          = state_q;
        period_d         = period_q;
        cont_d           = cont_q;
        tick_count_d     = tick_count_q;
        tm.tm_chipselect = 1'b0;
        tm.tm_write_n    = 1'b1;
        tm.tm_address    = '0;
        tm.tm_writedata  = '0;
`ifdef TIMER_MM_DRIVER_SNAPSHOT_EN
        irq_pend_d       = irq_pend_q;
        snap_lo_d        = snap_lo_q;
        snap_value_d     = snap_value_q;
`endif
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    period_d = cfg_period;
                    cont_d   = cfg_continuous;
                    state_d  = WR_PL;
                end
            end
            WR_PL: begin
                tm.tm_chipselect = 1'b1;
                tm.tm_write_n    = 1'b0;
                tm.tm_address    = REG_PERIODL;
                tm.tm_writedata  = period_q[15:0];
                state_d          = WR_PH;
            end
            WR_PH: begin
                tm.tm_chipselect = 1'b1;
                tm.tm_write_n    = 1'b0;
                tm.tm_address    = REG_PERIODH;
                tm.tm_writedata  = period_q[31:16];
                state_d          = WR_CTRL;
            end
            WR_CTRL: begin
                tm.tm_chipselect = 1'b1;
                tm.tm_write_n    = 1'b0;
                tm.tm_address    = REG_CONTROL;
                tm.tm_writedata  = ctrl_word(1'b0, 1'b1, cont_q, 1'b1);
                state_d          = RUN;
            end
            RUN: begin
                if (irq_now) begin
                    tick_count_d = tick_count_q + 1'b1;
                    state_d      = CLR_ST;
`ifdef TIMER_MM_DRIVER_SNAPSHOT_EN
                    irq_pend_d   = 1'b0;
`endif
                end else if (cfg_stop) begin
                    state_d = WR_STOP;
`ifdef TIMER_MM_DRIVER_SNAPSHOT_EN
                end else if (snap_req) begin
                    state_d = SNAP_WR;
`endif
                end else if (cfg_start) begin
                    period_d = cfg_period;
                    cont_d   = cfg_continuous;
                    state_d  = WR_PL;
                end
            end
            CLR_ST: begin
                tm.tm_chipselect = 1'b1;
                tm.tm_write_n    = 1'b0;
                tm.tm_address    = REG_STATUS;
                state_d          = cont_q ? RUN : IDLE;
            end
            WR_STOP: begin
                tm.tm_chipselect = 1'b1;
                tm.tm_write_n    = 1'b0;
                tm.tm_address    = REG_CONTROL;
                tm.tm_writedata  = ctrl_word(1'b1, 1'b0, 1'b0, 1'b0);
                state_d          = IDLE;
            end
`ifdef TIMER_MM_DRIVER_SNAPSHOT_EN
            SNAP_WR: begin
                tm.tm_chipselect = 1'b1;
                tm.tm_write_n    = 1'b0;
                tm.tm_address    = REG_SNAPL;
                irq_pend_d       = irq_pend_q | tm.tm_irq;
                state_d          = SNAP_RD_L;
            end
            SNAP_RD_L: begin
                tm.tm_chipselect = 1'b1;
                tm.tm_address    = REG_SNAPL;
                irq_pend_d       = irq_pend_q | tm.tm_irq;
                state_d          = SNAP_RD_H;
            end
            // Read latency is one cycle, so each half arrives in the following state.
            SNAP_RD_H: begin
                tm.tm_chipselect = 1'b1;
                tm.tm_address    = REG_SNAPH;
                snap_lo_d        = tm.tm_readdata;
                irq_pend_d       = irq_pend_q | tm.tm_irq;
                state_d          = SNAP_CAP;
            end
            SNAP_CAP: begin
                snap_value_d = {tm.tm_readdata, snap_lo_q};
                irq_pend_d   = irq_pend_q | tm.tm_irq;
                state_d      = RUN;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q != IDLE) && (state_q != RUN);
    assign running    = (state_q == RUN) || ((state_q == CLR_ST) && cont_q);
    assign tick       = (state_q == CLR_ST);
    assign tick_count = tick_count_q;

`ifdef TIMER_MM_DRIVER_SNAPSHOT_EN
    // The fresh value is presented in the same cycle as the valid pulse, then held.
    assign snap_valid = (state_q == SNAP_CAP);
    assign snap_value = (state_q == SNAP_CAP) ? {tm.tm_readdata, snap_lo_q} : snap_value_q;
`endif

endmodule

// File: tb/tb_timer_mm_driver.sv
// Scoreboard bench for timer_mm_driver; snapshot checks build with TIMER_MM_DRIVER_SNAPSHOT_EN.
module tb_timer_mm_driver;

    localparam int CW = 3;

    typedef struct packed {
        logic [2:0]  a;
        logic [15:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_start;
    logic [31:0]   cfg_period;
    logic          cfg_continuous;
    logic          cfg_stop;
    logic          busy, running, tick;
    logic [CW-1:0] tick_count;
`ifdef TIMER_MM_DRIVER_SNAPSHOT_EN
    logic          snap_req;
    logic [31:0]   snap_value;
    logic          snap_valid;
`endif

    timer_mm_driver_if bus ();

    timer_mm_driver #(.TICK_CNT_W(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_start      (cfg_start),
        .cfg_period     (cfg_period),
        .cfg_continuous (cfg_continuous),
        .cfg_stop       (cfg_stop),
`ifdef TIMER_MM_DRIVER_SNAPSHOT_EN
        .snap_req       (snap_req),
        .snap_value     (snap_value),
        .snap_valid     (snap_valid),
`endif
        .tm             (bus.master),
        .busy           (busy),
        .running        (running),
        .tick           (tick),
        .tick_count     (tick_count)
    );

    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    tick_seen = 0;
    int    exp_ticks = 0;
    int    exp_count = 0;
    wr_t   exp_q[$];
    int    wr_cyc[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Slave read model: registered data, one cycle after the address.
    always @(posedge clk) begin
        if (bus.tm_chipselect && bus.tm_write_n)
            bus.tm_readdata <= (bus.tm_address == 3'd4) ? 16'h00AB :
                               (bus.tm_address == 3'd5) ? 16'h0001 : 16'h0000;
        else
            bus.tm_readdata <= 16'h0000;
    end

    // Write monitor pops the scoreboard.
    always @(negedge clk) begin
        if (tick) tick_seen++;
        if (bus.tm_chipselect && !bus.tm_write_n) begin
            wr_t got;
            got.a = bus.tm_address;
            got.d = bus.tm_writedata;
            $display("[TB] cyc %0d write addr=%0d data=0x%04h", cyc, got.a, got.d);
            wr_cyc.push_back(cyc);
            chk("wr_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) chk("wr", 32'(got), 32'(exp_q.pop_front()));
        end
    end

    task automatic push_wr(input logic [2:0] a, input logic [15:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic start(input logic [31:0] p, input logic c);
        @(posedge clk); #1;
        cfg_start = 1'b1; cfg_period = p; cfg_continuous = c;
        push_wr(3'd2, p[15:0]);
        push_wr(3'd3, p[31:16]);
        push_wr(3'd1, {13'd0, 1'b1, c, 1'b1});
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic bump_tick();
        push_wr(3'd0, 16'h0000);
        exp_count = (exp_count + 1) % (1 << CW);
        exp_ticks++;
    endtask

    task automatic pulse_irq();
        @(posedge clk); #1;
        bus.tm_irq = 1'b1;
        bump_tick();
        @(posedge clk); #1;
        bus.tm_irq = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic pulse_stop(input logic expect_wr);
        @(posedge clk); #1;
        cfg_stop = 1'b1;
        if (expect_wr) push_wr(3'd1, 16'h0008);
        @(posedge clk); #1;
        cfg_stop = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        reset = 1'b1; cfg_start = 1'b0; cfg_period = '0; cfg_continuous = 1'b0;
        cfg_stop = 1'b0; bus.tm_irq = 1'b0;
`ifdef TIMER_MM_DRIVER_SNAPSHOT_EN
        snap_req = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cs",     32'(bus.tm_chipselect), 32'd0);
        chk("rst_wn",     32'(bus.tm_write_n),    32'd1);
        chk("rst_addr",   32'(bus.tm_address),    32'd0);
        chk("rst_wdata",  32'(bus.tm_writedata),  32'd0);
        chk("rst_busy",   32'(busy),              32'd0);
        chk("rst_run",    32'(running),           32'd0);
        chk("rst_tick",   32'(tick),              32'd0);
        chk("rst_count",  32'(tick_count),        32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Program continuous timer: three back-to-back writes, then running.
        wr_cyc.delete();
        start(32'h0001_2345, 1'b1);
        drain("prog_drain");
        chk("prog_n_wr",  32'(wr_cyc.size()), 32'd3);
        if (wr_cyc.size() == 3) begin
            chk("prog_gap1", 32'(wr_cyc[1] - wr_cyc[0]), 32'd1);
            chk("prog_gap2", 32'(wr_cyc[2] - wr_cyc[1]), 32'd1);
        end
        chk("prog_run",  32'(running), 32'd1);
        chk("prog_busy", 32'(busy),    32'd0);

        // Three timeouts in continuous mode.
        for (int i = 0; i < 3; i++) pulse_irq();
        drain("cont_drain");
        chk("cont_count", 32'(tick_count), 32'(exp_count));
        chk("cont_ticks", 32'(tick_seen),  32'(exp_ticks));
        chk("cont_run",   32'(running),    32'd1);

        pulse_stop(1'b1);
        drain("stop_drain");
        chk("stop_run",  32'(running), 32'd0);
        chk("stop_busy", 32'(busy),    32'd0);

        // One-shot: single clear then idle; a stop while idle does nothing.
        start(32'h0000_0010, 1'b0);
        drain("oneshot_prog");
        pulse_irq();
        drain("oneshot_drain");
        chk("oneshot_run",   32'(running),    32'd0);
        chk("oneshot_busy",  32'(busy),       32'd0);
        chk("oneshot_count", 32'(tick_count), 32'(exp_count));
        pulse_stop(1'b0);
        drain("idle_stop");

        // irq and stop together: irq wins, stop is dropped until re-asserted.
        start(32'h0000_0100, 1'b1);
        drain("coin_prog");
        @(posedge clk); #1;
        bus.tm_irq = 1'b1; cfg_stop = 1'b1;
        bump_tick();
        @(posedge clk); #1;
        bus.tm_irq = 1'b0; cfg_stop = 1'b0;
        repeat (4) @(posedge clk);
        drain("coin_drain");
        chk("coin_run",   32'(running),    32'd1);
        chk("coin_count", 32'(tick_count), 32'(exp_count));
        pulse_stop(1'b1);
        drain("coin_stop");
        chk("coin_stop_run", 32'(running), 32'd0);

`ifdef TIMER_MM_DRIVER_SNAPSHOT_EN
        // Snapshot with an irq arriving mid-sequence.
        start(32'h0000_0200, 1'b1);
        drain("snap_prog");
        @(posedge clk); #1;
        snap_req = 1'b1;
        push_wr(3'd4, 16'h0000);
        @(posedge clk); #1;
        snap_req = 1'b0;
        @(posedge clk); #1;
        bus.tm_irq = 1'b1;
        bump_tick();
        @(posedge clk); #1;
        bus.tm_irq = 1'b0;
        @(negedge clk);
        chk("snap_early", 32'(snap_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("snap_valid", 32'(snap_valid), 32'd1);
        chk("snap_value", snap_value,      32'h0001_00AB);
        @(negedge clk);
        chk("snap_pulse", 32'(snap_valid), 32'd0);
        chk("snap_hold",  snap_value,      32'h0001_00AB);
        drain("snap_drain");
        chk("snap_count", 32'(tick_count), 32'(exp_count));
        pulse_stop(1'b1);
        drain("snap_stop");
`endif

        // Reset during WR_PH: no control write, everything cleared.
        @(posedge clk); #1;
        cfg_start = 1'b1; cfg_period = 32'hABCD_1234; cfg_continuous = 1'b1;
        push_wr(3'd2, 16'h1234);
        push_wr(3'd3, 16'hABCD);
        @(posedge clk); #1;
        cfg_start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_count = 0;
        @(negedge clk);
        chk("mid_rst_cs",    32'(bus.tm_chipselect), 32'd0);
        chk("mid_rst_busy",  32'(busy),              32'd0);
        chk("mid_rst_count", 32'(tick_count),        32'd0);
        repeat (4) @(posedge clk);
        drain("mid_rst_drain");

        // Counter wraps modulo 2^CW.
        start(32'h0000_0020, 1'b1);
        drain("wrap_prog");
        for (int i = 0; i < 9; i++) pulse_irq();
        drain("wrap_drain");
        chk("wrap_count", 32'(tick_count), 32'(exp_count));
        chk("all_ticks",  32'(tick_seen),  32'(exp_ticks));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/timer_mm_driver.md
TIMER_MM_DRIVER -- requirements
Module: timer_mm_driver

Interface
REQ-001 SHALL have parameter TICK_CNT_W, default 16, width of tick counter.
REQ-002 SHALL have ports: clk  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port cfg_start  in  1  one-cycle request to program and start the timer.
REQ-005 SHALL have port cfg_period  in  32  period value, sampled when cfg_start is accepted.
REQ-006 SHALL have port cfg_continuous  in  1  continuous mode, sampled with cfg_period.
REQ-007 SHALL have port cfg_stop  in  1  one-cycle request to stop the timer.
REQ-008 SHALL have ports tm_address out 3, tm_chipselect out 1, tm_write_n out 1, tm_writedata out 16: Avalon-MM master to the timer slave; no waitrequest; fixed read latency 1.
REQ-009 SHALL have ports tm_readdata in 16 and tm_irq in 1 from the timer slave.
REQ-010 SHALL have ports busy out 1, running out 1, tick out 1 (one-cycle pulse per serviced timeout) and tick_count out TICK_CNT_W.

Function
REQ-011 SHALL implement an FSM with states IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_ST and WR_STOP, spending exactly one cycle in each non-IDLE, non-RUN state.
REQ-012 SHALL accept cfg_start only in IDLE or RUN: latch period/mode, go to WR_PL; ignore it in all other states.
REQ-013 SHALL write in order: WR_PL addr 2 data period[15:0]; WR_PH addr 3 data period[31:16]; WR_CTRL addr 1 data {0,1,cont,1} (stop=0, start=1, continuous, irq-enable=1); then enter RUN.
REQ-014 SHALL in RUN, on tm_irq=1, go to CLR_ST, write addr 0 data 0, pulse tick, and increment tick_count modulo 2^TICK_CNT_W (wrap to 0).
REQ-015 SHALL return from CLR_ST to RUN if continuous, else to IDLE with running=0.
REQ-016 SHALL on cfg_stop in RUN go to WR_STOP, write addr 1 data 4'b1000, then enter IDLE; cfg_stop in other states is ignored.
REQ-017 SHALL give RUN priority tm_irq > cfg_stop > cfg_start when they coincide.
REQ-018 SHALL drive tm_chipselect=1 only in bus-access states, tm_write_n=0 only on writes, and tm_address/tm_writedata=0 otherwise.
REQ-019 SHALL assert busy in every state except IDLE and RUN, and running in RUN and CLR_ST (CLR_ST only when continuous).

Reset
REQ-020 SHALL on reset force IDLE and drive busy, running, tick, tick_count, tm_chipselect, tm_address, tm_writedata = 0 and tm_write_n = 1, including mid-sequence.
REQ-021 SHALL not sample tm_irq during the reset cycle.

Configuration
REQ-022 SHALL provide macro TIMER_MM_DRIVER_SNAPSHOT_EN; when defined, add ports snap_req in 1, snap_value out 32, snap_valid out 1, plus states SNAP_WR, SNAP_RD_L, SNAP_RD_H, SNAP_CAP.
REQ-023 SHALL with the macro, on snap_req in RUN (priority below cfg_stop): SNAP_WR writes addr 4 data 0; SNAP_RD_L reads addr 4; SNAP_RD_H reads addr 5 and captures tm_readdata as the low half; SNAP_CAP captures the high half, pulses snap_valid for one cycle, and returns to RUN.
REQ-024 SHALL defer a tm_irq arriving during snapshot states until RUN is re-entered, where it is serviced.
REQ-025 SHALL without the macro omit snapshot ports and states and ignore tm_readdata; snap_value/snap_valid reset to 0 when present.

Structure
REQ-026 SHALL place timer register offsets (0..5), control bit positions and the state enum in shared package timer_mm_pkg.
REQ-027 SHALL be a single module; no sub-module required.

Verification
REQ-028 SHALL cover: cfg_start with period 0x0001_2345, cont=1 -> writes (2,0x2345),(3,0x0001),(1,0x0007) on consecutive cycles, then running=1.
REQ-029 SHALL cover: three tm_irq pulses in continuous mode -> three writes (0,0x0000), three tick pulses, tick_count=3.
REQ-030 SHALL cover: cont=0, one tm_irq -> one clear write, running=0, state IDLE.
REQ-031 SHALL cover: tm_irq and cfg_stop in the same RUN cycle -> CLR_ST first, then cfg_stop ignored unless re-asserted in RUN.
REQ-032 SHALL cover: reset asserted during WR_PH -> next cycle tm_chipselect=0, busy=0, tick_count=0, with no write to addr 1.
REQ-033 SHALL cover, with the macro: snap_req while the slave returns 0x00AB then 0x0001 -> snap_value=0x0001_00AB, with snap_valid pulsing 4 cycles after snap_req.
